// File: rtl/step_sequencer_if.sv
// Bundles the step sequencer's slow-clock, control and status signals.
// The master side drives the inputs and watches the step strobes; the slave side is the sequencer.
interface step_sequencer_if #(
  parameter int IDX_W = 3
);
  logic             clk_1Hz;
  logic             start;
  logic             pause;
  logic             step_btn;
  logic             step_pulse;
  logic [IDX_W-1:0] step_idx;
  logic             busy;
  logic             done;
  logic             sec_led;

  modport master (
    output clk_1Hz, start, pause, step_btn,
    input  step_pulse, step_idx, busy, done, sec_led
  );

  modport slave (
    input  clk_1Hz, start, pause, step_btn,
    output step_pulse, step_idx, busy, done, sec_led
  );
endinterface

// File: rtl/step_sequencer.sv
// Converts the 1 Hz divider output into one-cycle step strobes in the 50 MHz domain and walks
// the coprocessor through a NUM_STEPS sequence, with pause and a debounced single-step button.
module step_sequencer #(
  parameter int NUM_STEPS  = 8,
  parameter int IDX_W      = 3,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic           clk_50MHz,
  input  logic           reset,
  step_sequencer_if.slave bus
);

  localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Slow-clock synchronizer and edge detector
  logic hz_s1, hz_s2, hz_prev;
  logic tick;

  // Button synchronizer and debouncer
  logic             btn_s1, btn_s2;
  logic             deb_state;
  logic [CNT_W-1:0] deb_cnt;
  logic             step_req;

  // Start edge detector
  logic start_q;
  logic start_rise;

  // Sequencer FSM
  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             pulse, pulse_next;
  logic             busy_q, done_q;

  assign tick       = hz_s2 & ~hz_prev;
  assign start_rise = bus.start & ~start_q;

  // Two-flop sync of clk_1Hz plus a delayed copy for rising-edge detection
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      hz_s1   <= 1'b0;
      hz_s2   <= 1'b0;
      hz_prev <= 1'b0;
    end else begin
      hz_s1   <= bus.clk_1Hz;
      hz_s2   <= hz_s1;
      hz_prev <= hz_s2;
    end
  end

  // Remember the previous start level so only a rising edge (re)starts a sequence
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= bus.start;
    end
  end

  // Two-flop sync of the raw button
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= bus.step_btn;
      btn_s2 <= btn_s1;
    end
  end

  // Accept a button change only after it has been stable for DEB_CYCLES; flag each new press
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      deb_state <= 1'b0;
      deb_cnt   <= '0;
      step_req  <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (btn_s2 == deb_state) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_state <= btn_s2;
        deb_cnt   <= '0;
        step_req  <= btn_s2;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state, next-index and strobe decode; pause outranks tick, the last step parks in DONE
  always_comb begin
    state_next = state;
    idx_next   = idx;
    pulse_next = 1'b0;
    unique case (state)
      IDLE: begin
        idx_next = '0;
        if (start_rise) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.pause) begin
          state_next = PAUSED;
        end else if (tick) begin
          pulse_next = 1'b1;
          if (idx == IDX_LAST) begin
            state_next = DONE;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      PAUSED: begin
        if (!bus.pause) begin
          state_next = RUN;
        end
        if (step_req) begin
          pulse_next = 1'b1;
          if (idx == IDX_LAST) begin
            state_next = DONE;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (start_rise) begin
          state_next = RUN;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // State, index and registered outputs; busy/done decode the state being entered so they
  // line up with the registered state
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      pulse  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      pulse  <= pulse_next;
      busy_q <= (state_next == RUN) || (state_next == PAUSED);
      done_q <= (state_next == DONE);
    end
  end

  // The strobe carries the index it was issued for; idx has already advanced by then
  logic [IDX_W-1:0] pulse_idx;

  // Hold the index of the issued step so step_idx is valid while step_pulse is high
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      pulse_idx <= '0;
    end else begin
      pulse_idx <= pulse_next ? idx : idx_next;
    end
  end

  assign bus.step_pulse = pulse;
  assign bus.step_idx   = pulse_idx;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sec_led    = hz_s2;

endmodule
